// File: rtl/axi_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_sram_slave: AXI3 slave backed by a byte-strobed word SRAM, one       |
// | transaction in flight, optional read wait states.  Revision 1.0          |
// +--------------------------------------------------------------------------+
module axi_sram_slave #(
  parameter int ADDR_W = 16,
  parameter int LAT    = 0
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_MEM  = 3'd1,
    RD_WAIT = 3'd2,
    RD_RESP = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5
  } state_t;

  localparam logic [3:0] LAT_LAST = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

  state_t state;
  state_t state_nxt;

  logic        rd_prio;
  logic [3:0]  id;
  logic [31:0] addr;
  logic [3:0]  len;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic [3:0]  beat;
  logic [3:0]  wait_cnt;
  logic        wr_err;

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  logic [ADDR_W-1:0] word;
  logic [31:0]       addr_nxt;
  logic              last_beat;
  logic              r_hs;
  logic              w_hs;
  logic              unused;

  assign word      = addr[ADDR_W+1:2];
  // FIXED holds the address; every other burst type steps like INCR
  assign addr_nxt  = (burst == 2'b00) ? addr : addr + (32'd1 << size);
  assign last_beat = (beat == len);
  assign r_hs      = rvalid & rready;
  assign w_hs      = wvalid & wready;

  assign rid   = id;
  assign rresp = 2'b00;
  assign rlast = (state == RD_RESP) && last_beat;
  assign bid   = id;
  assign bresp = ((state == WR_RESP) && wr_err) ? 2'b10 : 2'b00;

  assign unused = ^{arlock, arcache, arprot, awlock, awcache, awprot,
                    arlen[7:4], awlen[7:4]};

  always_ff @(posedge aclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    rvalid    = 1'b0;
    bvalid    = 1'b0;
    case (state)
      IDLE: begin
        arready = arvalid & (~awvalid | rd_prio);
        awready = awvalid & (~arvalid | ~rd_prio);
        if (arready)      state_nxt = RD_MEM;
        else if (awready) state_nxt = WR_DATA;
      end
      RD_MEM: begin
        if (LAT == 0) state_nxt = RD_RESP;
        else          state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_cnt == LAT_LAST) state_nxt = RD_RESP;
      end
      RD_RESP: begin
        rvalid = 1'b1;
        if (rready) state_nxt = last_beat ? IDLE : RD_MEM;
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid && last_beat) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      rd_prio  <= 1'b1;
      id       <= 4'd0;
      addr     <= 32'd0;
      len      <= 4'd0;
      size     <= 3'd0;
      burst    <= 2'b00;
      beat     <= 4'd0;
      wait_cnt <= 4'd0;
      wr_err   <= 1'b0;
      rdata    <= 32'd0;
    end else begin
      if (arready) begin
        id      <= arid;
        addr    <= araddr;
        len     <= arlen[3:0];
        size    <= arsize;
        burst   <= arburst;
        beat    <= 4'd0;
        rd_prio <= 1'b0;
      end else if (awready) begin
        id      <= awid;
        addr    <= awaddr;
        len     <= awlen[3:0];
        size    <= awsize;
        burst   <= awburst;
        beat    <= 4'd0;
        wr_err  <= 1'b0;
        rd_prio <= 1'b1;
      end

      if (state == RD_MEM)       wait_cnt <= 4'd0;
      else if (state == RD_WAIT) wait_cnt <= wait_cnt + 4'd1;

      // Capture the word on the edge that enters RD_RESP so it stays stable while stalled
      if (state_nxt == RD_RESP && state != RD_RESP) rdata <= mem[word];

      if (r_hs && !last_beat) begin
        addr <= addr_nxt;
        beat <= beat + 4'd1;
      end

      if (w_hs) begin
        addr <= addr_nxt;
        beat <= beat + 4'd1;
        if (wid != id || wlast != last_beat) wr_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hs && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire
